// File: rtl/seq_word_serializer_pkg.sv
// Shared types for the "101" sequence detector path and its word serializer feeder.
package seq_word_serializer_pkg;

  typedef enum logic [1:0] {DET_S0, DET_S1, DET_S10} det_state_t;

  typedef enum logic {SER_IDLE, SER_SHIFT} ser_state_t;

  localparam int SER_DEF_WIDTH = 8;

endpackage

// File: rtl/seq_word_hold_buf.sv
// One-entry holding register that lets the next word wait while the current one shifts out.
module seq_word_hold_buf
  import seq_word_serializer_pkg::*;
#(
  parameter int WIDTH = SER_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_word,
  output logic             o_full,
  output logic             o_ready
);

  logic [WIDTH-1:0] r_word;
  logic             r_full;

  // load only happens while empty and pop only while full, so they never collide
  always_ff @(posedge clk) begin
    if (rst) begin
      r_word <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_word <= i_word;
      r_full <= 1'b1;
    end else if (i_pop) begin
      r_full <= 1'b0;
    end
  end

  assign o_word  = r_word;
  assign o_full  = r_full;
  assign o_ready = !r_full;

endmodule

// File: rtl/seq_word_serializer.sv
// Parallel-to-serial feeder: valid/ready words in, one bit per clock out on seq.
// Handshake: a word moves when word_valid && word_ready at a clock edge; word_ready depends on registers only.
module seq_word_serializer
  import seq_word_serializer_pkg::*;
#(
  parameter int   WIDTH     = SER_DEF_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             seq,
  output logic             seq_valid,
  output logic             word_done,
  output logic             busy,
  output ser_state_t       dbg_state
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_CNT = CW'(WIDTH - 1);

  ser_state_t       r_state, w_state_nxt;
  logic [WIDTH-1:0] r_sh, w_sh_nxt, w_sh_shifted;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             w_xfer, w_last;
  logic             w_hold_load, w_hold_pop, w_hold_full, w_hold_ready;
  logic [WIDTH-1:0] w_hold_word;

  seq_word_hold_buf #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_hold_load),
    .i_word  (word_in),
    .i_pop   (w_hold_pop),
    .o_word  (w_hold_word),
    .o_full  (w_hold_full),
    .o_ready (w_hold_ready)
  );

  assign w_xfer       = word_valid && w_hold_ready;
  assign w_last       = (r_cnt == LAST_CNT);
  assign w_sh_shifted = MSB_FIRST ? {r_sh[WIDTH-2:0], 1'b0} : {1'b0, r_sh[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= SER_IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sh    <= w_sh_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_cnt_nxt   = r_cnt;
    w_hold_load = 1'b0;
    w_hold_pop  = 1'b0;
    case (r_state)
      SER_IDLE: begin
        if (w_xfer) begin
          w_sh_nxt    = word_in;
          w_cnt_nxt   = '0;
          w_state_nxt = SER_SHIFT;
        end
      end
      SER_SHIFT: begin
        if (!w_last) begin
          w_sh_nxt    = w_sh_shifted;
          w_cnt_nxt   = r_cnt + 1'b1;
          w_hold_load = w_xfer;
        end else if (w_hold_full) begin
          // held word follows the last bit with no idle gap
          w_sh_nxt   = w_hold_word;
          w_cnt_nxt  = '0;
          w_hold_pop = 1'b1;
        end else if (w_xfer) begin
          w_sh_nxt  = word_in;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt   = '0;
          w_state_nxt = SER_IDLE;
        end
      end
      default: w_state_nxt = SER_IDLE;
    endcase
  end

  assign seq_valid  = (r_state == SER_SHIFT);
  assign seq        = seq_valid ? (MSB_FIRST ? r_sh[WIDTH-1] : r_sh[0]) : IDLE_BIT;
  assign word_done  = seq_valid && w_last;
  assign busy       = seq_valid || w_hold_full;
  assign word_ready = w_hold_ready;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_seq_word_serializer.sv
// Bench for seq_word_serializer: an 8-bit MSB-first instance and a 4-bit LSB-first instance.
module tb_seq_word_serializer;
  import seq_word_serializer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] a_word_in = '0;
  logic       a_word_valid = 1'b0;
  logic       a_word_ready, a_seq, a_seq_valid, a_word_done, a_busy;
  ser_state_t a_dbg;

  logic [3:0] b_word_in = '0;
  logic       b_word_valid = 1'b0;
  logic       b_word_ready, b_seq, b_seq_valid, b_word_done, b_busy;
  ser_state_t b_dbg;

  seq_word_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_dut_a (
    .clk(clk), .rst(rst), .word_in(a_word_in), .word_valid(a_word_valid),
    .word_ready(a_word_ready), .seq(a_seq), .seq_valid(a_seq_valid),
    .word_done(a_word_done), .busy(a_busy), .dbg_state(a_dbg)
  );

  seq_word_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_dut_b (
    .clk(clk), .rst(rst), .word_in(b_word_in), .word_valid(b_word_valid),
    .word_ready(b_word_ready), .seq(b_seq), .seq_valid(b_seq_valid),
    .word_done(b_word_done), .busy(b_busy), .dbg_state(b_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_a[$];
  logic [1:0] exp_b[$];
  logic [1:0] mon_a_e, mon_b_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // status vector {seq, seq_valid, word_done, busy, word_ready}; idle is 5'b00001
  function automatic logic [31:0] a_status();
    return 32'({a_seq, a_seq_valid, a_word_done, a_busy, a_word_ready});
  endfunction

  function automatic logic [31:0] b_status();
    return 32'({b_seq, b_seq_valid, b_word_done, b_busy, b_word_ready});
  endfunction

  // scoreboard monitors: every data bit must match the next expected {bit, last}
  always @(negedge clk) begin
    if (a_seq_valid) begin
      if (exp_a.size() == 0) check("a_unexpected_bit", 32'(a_seq_valid), 32'd0);
      else begin
        mon_a_e = exp_a.pop_front();
        check("a_seq_done", 32'({a_seq, a_word_done}), 32'(mon_a_e));
      end
    end
  end

  always @(negedge clk) begin
    if (b_seq_valid) begin
      if (exp_b.size() == 0) check("b_unexpected_bit", 32'(b_seq_valid), 32'd0);
      else begin
        mon_b_e = exp_b.pop_front();
        check("b_seq_done", 32'({b_seq, b_word_done}), 32'(mon_b_e));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // exp_seq lists the bits in emission order, first bit at the MSB
  task automatic send_a(input logic [7:0] w, input logic [7:0] exp_seq, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    a_word_in = w;
    a_word_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (a_word_ready) begin
        ok = 1'b1;
        break;
      end
      waits++;
      step();
    end
    if (!ok) check("a_send_timeout", 32'd0, 32'd1);
    else for (int i = 0; i < 8; i++) exp_a.push_back({exp_seq[7-i], (i == 7)});
    step();
    a_word_valid = 1'b0;
  endtask

  task automatic send_b(input logic [3:0] w, input logic [3:0] exp_seq, output int waits);
    bit ok;
    ok = 1'b0;
    waits = 0;
    b_word_in = w;
    b_word_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (b_word_ready) begin
        ok = 1'b1;
        break;
      end
      waits++;
      step();
    end
    if (!ok) check("b_send_timeout", 32'd0, 32'd1);
    else for (int i = 0; i < 4; i++) exp_b.push_back({exp_seq[3-i], (i == 3)});
    step();
    b_word_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    det_state_t ds;
    int pulses;
    int pos[2];

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_a", a_status(), 32'h01);
    check("reset_b", b_status(), 32'h01);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_a", a_status(), 32'h01);
      check("idle_b", b_status(), 32'h01);
    end

    // single word: 8 contiguous bits starting the cycle after the transfer
    step();
    send_a(8'hA5, 8'b1010_0101, w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("a5_valid", 32'(a_seq_valid), 32'd1);
      check("a5_done", 32'(a_word_done), 32'(i == 7));
    end
    @(negedge clk);
    check("a5_idle_after", a_status(), 32'h01);

    // back-to-back: second word waits in hold, ready low N+2..N+8
    step();
    send_a(8'hFF, 8'hFF, w);
    send_a(8'h00, 8'h00, w);
    check("b2b_second_no_wait", 32'(w), 32'd0);
    for (int c = 2; c <= 16; c++) begin
      @(negedge clk);
      check("b2b_valid", 32'(a_seq_valid), 32'd1);
      check("b2b_ready", 32'(a_word_ready), 32'(c >= 9));
    end
    @(negedge clk);
    check("b2b_idle_after", a_status(), 32'h01);

    // reset during a word with another word held
    step();
    send_a(8'hA5, 8'b1010_0101, w);
    send_a(8'h3C, 8'b0011_1100, w);
    check("rst_busy_before", 32'(a_busy), 32'd1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_a.delete();
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check("rst_mid_idle", a_status(), 32'h01);
    end

    // 4-bit LSB-first: third word stalls until the hold empties
    step();
    send_b(4'b0110, 4'b0110, w);
    send_b(4'b1001, 4'b1001, w);
    check("b_second_no_wait", 32'(w), 32'd0);
    send_b(4'b1100, 4'b0011, w);
    check("b_third_wait", 32'(w), 32'd3);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_b.size() == 0 && !b_busy) break;
    end
    check("b_drained", 32'(exp_b.size()), 32'd0);
    check("b_idle_after", b_status(), 32'h01);

    // overlapping "101" detector watching seq
    step();
    send_a(8'b0101_0100, 8'b0101_0100, w);
    ds = DET_S0;
    pulses = 0;
    pos[0] = -1;
    pos[1] = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_seq_valid) begin
        if (ds == DET_S10 && a_seq) begin
          if (pulses < 2) pos[pulses] = i;
          pulses++;
        end
        case (ds)
          DET_S0:  ds = a_seq ? DET_S1 : DET_S0;
          DET_S1:  ds = a_seq ? DET_S1 : DET_S10;
          default: ds = a_seq ? DET_S1 : DET_S0;
        endcase
      end
    end
    check("det_pulse_count", 32'(pulses), 32'd2);
    check("det_pulse0_bit", 32'(pos[0]), 32'd3);
    check("det_pulse1_bit", 32'(pos[1]), 32'd5);

    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (exp_a.size() == 0 && !a_busy) break;
    end
    check("a_drained", 32'(exp_a.size()), 32'd0);
    check("a_final_idle", a_status(), 32'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
